// File: rtl/strength_pkg.sv
// Shared types and the strength-comparison rule for the multi-driver net resolver.
package strength_pkg;

    localparam int MAX_STR_W = 8;

    typedef enum logic [2:0] {
        STR_HIGHZ  = 3'd0,
        STR_SMALL  = 3'd1,
        STR_MEDIUM = 3'd2,
        STR_WEAK   = 3'd3,
        STR_LARGE  = 3'd4,
        STR_PULL   = 3'd5,
        STR_STRONG = 3'd6,
        STR_SUPPLY = 3'd7
    } strength_t;

    typedef enum logic [1:0] {
        NET_0 = 2'b00,
        NET_1 = 2'b01,
        NET_Z = 2'b10,
        NET_X = 2'b11
    } net_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // The strongest 0-driver is compared against the strongest 1-driver; equal nonzero maxima clash to X.
    function automatic net_t resolve(input logic [MAX_STR_W-1:0] max0,
                                     input logic [MAX_STR_W-1:0] max1);
        net_t net;
        if (max0 == '0 && max1 == '0) begin
            net = NET_Z;
        end else if (max1 > max0) begin
            net = NET_1;
        end else if (max0 > max1) begin
            net = NET_0;
        end else begin
            net = NET_X;
        end
        return net;
    endfunction

endpackage

// File: rtl/strength_scan_acc.sv
// Sequential scan accumulator: walks the slots one per step and tracks the
// strongest 0-driver and the strongest 1-driver seen so far.
module strength_scan_acc
    import strength_pkg::*;
#(
    parameter int N_DRV = 3,
    parameter int STR_W = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic             i_val,
    input  logic [STR_W-1:0] i_str0,
    input  logic [STR_W-1:0] i_str1,
    output logic [IDX_W-1:0] o_ptr,
    output logic [STR_W-1:0] o_max0,
    output logic [STR_W-1:0] o_max1,
    output logic             o_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DRV - 1);

    logic [IDX_W-1:0] r_ptr;
    logic [STR_W-1:0] r_max0;
    logic [STR_W-1:0] r_max1;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_ptr  <= '0;
            r_max0 <= '0;
            r_max1 <= '0;
        end else if (i_step) begin
            if (i_val) begin
                if (i_str1 > r_max1) begin
                    r_max1 <= i_str1;
                end
            end else begin
                if (i_str0 > r_max0) begin
                    r_max0 <= i_str0;
                end
            end
            r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + IDX_W'(1);
        end
    end

    assign o_ptr  = r_ptr;
    assign o_max0 = r_max0;
    assign o_max1 = r_max1;
    assign o_done = (r_ptr == LAST_IDX);

endmodule

// File: rtl/strength_net_resolver.sv
// Multi-driver net resolution stage: holds per-driver drive slots, rescans them
// after every accepted update and registers the resolved 4-state net value.
module strength_net_resolver
    import strength_pkg::*;
#(
    parameter  int N_DRV = 3,
    parameter  int STR_W = 3,
    parameter  int CNT_W = 8,
    localparam int IDX_W = (N_DRV > 1) ? $clog2(N_DRV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drv_valid_i,
    output logic             drv_ready_o,
    input  logic [IDX_W-1:0] drv_idx_i,
    input  logic             drv_val_i,
    input  logic [STR_W-1:0] drv_str0_i,
    input  logic [STR_W-1:0] drv_str1_i,
    output logic [1:0]       net_o,
    output logic             net_changed_o,
    output logic [CNT_W-1:0] conflict_cnt_o,
    output logic             finish_o,
    output logic             busy_o
);

    state_t           r_state;
    state_t           w_nextState;

    logic [N_DRV-1:0] r_slotVal;
    logic [STR_W-1:0] r_slotStr0 [N_DRV];
    logic [STR_W-1:0] r_slotStr1 [N_DRV];

    net_t             r_net;
    logic             r_netChanged;
    logic             r_finish;
    logic [CNT_W-1:0] r_conflictCnt;

    logic             w_idxOk;
    logic             w_write;
    logic             w_clear;
    logic             w_step;
    logic             w_done;
    logic [IDX_W-1:0] w_ptr;
    logic [STR_W-1:0] w_max0;
    logic [STR_W-1:0] w_max1;
    net_t             w_newNet;

    assign w_idxOk = 32'(drv_idx_i) < 32'(N_DRV);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Out-of-range requests are still handshaken so the requester never stalls on them.
    always_comb begin
        w_nextState = r_state;
        drv_ready_o = 1'b0;
        busy_o      = 1'b0;
        w_write     = 1'b0;
        w_clear     = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                drv_ready_o = 1'b1;
                if (drv_valid_i && w_idxOk) begin
                    w_write     = 1'b1;
                    w_clear     = 1'b1;
                    w_nextState = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy_o = 1'b1;
                w_step = 1'b1;
                if (w_done) begin
                    w_nextState = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                busy_o      = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slotVal <= '0;
            for (int i = 0; i < N_DRV; i++) begin
                r_slotStr0[i] <= '0;
                r_slotStr1[i] <= '0;
            end
        end else if (w_write) begin
            r_slotVal[drv_idx_i]  <= drv_val_i;
            r_slotStr0[drv_idx_i] <= drv_str0_i;
            r_slotStr1[drv_idx_i] <= drv_str1_i;
        end
    end

    strength_scan_acc #(
        .N_DRV (N_DRV),
        .STR_W (STR_W),
        .IDX_W (IDX_W)
    ) u_scanAcc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_step  (w_step),
        .i_val   (r_slotVal[w_ptr]),
        .i_str0  (r_slotStr0[w_ptr]),
        .i_str1  (r_slotStr1[w_ptr]),
        .o_ptr   (w_ptr),
        .o_max0  (w_max0),
        .o_max1  (w_max1),
        .o_done  (w_done)
    );

    assign w_newNet = resolve(MAX_STR_W'(w_max0), MAX_STR_W'(w_max1));

    // Pulses default low every cycle and are raised only on the commit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_net         <= NET_Z;
            r_netChanged  <= 1'b0;
            r_finish      <= 1'b0;
            r_conflictCnt <= '0;
        end else begin
            r_netChanged <= 1'b0;
            r_finish     <= 1'b0;
            if (r_state == ST_COMMIT) begin
                r_net        <= w_newNet;
                r_netChanged <= (w_newNet != r_net);
                r_finish     <= (w_newNet == NET_1) && (r_net != NET_1);
                if (w_newNet == NET_X && r_conflictCnt != '1) begin
                    r_conflictCnt <= r_conflictCnt + CNT_W'(1);
                end
            end
        end
    end

    assign net_o          = r_net;
    assign net_changed_o  = r_netChanged;
    assign finish_o       = r_finish;
    assign conflict_cnt_o = r_conflictCnt;

endmodule

// File: doc/strength_net_resolver.md
Name: strength_net_resolver

Overview:
- Multi-driver net resolution stage. It sits directly upstream of the net consumer, i.e. logic that samples a net and acts on it, such as finishing when the net is 1.
- Holds one registered drive slot per driver. Each slot has a value and a strength0/strength1 pair, updated through a valid/ready request port.
- After each accepted update it rescans all slots sequentially and computes the Verilog-style resolved 4-state net value.
- Registers the result and emits change, conflict-count and first-high (finish) indications.

Parameters:
- N_DRV, 3, number of driver slots (>=1).
- STR_W, 3, strength code width. Encoding: 0=highz, 1=small, 2=medium, 3=weak, 4=large, 5=pull, 6=strong, 7=supply.
- CNT_W, 8, conflict counter width.
- IDX_W, $clog2(N_DRV) (min 1), slot index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- drv_valid_i  in  1  update request valid.
- drv_ready_o  out  1  request accepted when valid&ready.
- drv_idx_i  in  IDX_W  target slot.
- drv_val_i  in  1  driven logic value.
- drv_str0_i  in  STR_W  strength used when value is 0.
- drv_str1_i  in  STR_W  strength used when value is 1.
- net_o  out  2  resolved net: 00=0, 01=1, 10=Z, 11=X.
- net_changed_o  out  1  one-cycle pulse when net_o changes at commit.
- conflict_cnt_o  out  CNT_W  count of commits resolving to X; saturating.
- finish_o  out  1  one-cycle pulse when net_o goes from any non-1 value to 1.
- busy_o  out  1  high during SCAN/COMMIT.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0:
  - all slots cleared to val=0, str0=0, str1=0 (highz);
  - net_o=10 (Z); net_changed_o=0; finish_o=0; conflict_cnt_o=0;
  - state=IDLE, so drv_ready_o=1 and busy_o=0.
  - Reset wins over any concurrent request or scan. A scan in progress is abandoned with no commit.
- Effective strength of a slot is str1 if val=1, else str0. Strength 0 contributes nothing.
- FSM states IDLE, SCAN, COMMIT:
  - IDLE: drv_ready_o=1.
    - On valid&ready with idx<N_DRV: write the slot, clear the scan accumulators (max0=0, max1=0, ptr=0), go to SCAN.
    - If idx>=N_DRV: the request is accepted and dropped. Stay in IDLE; no commit, no pulses.
  - SCAN: drv_ready_o=0. Each cycle examines slot[ptr]:
    - if val=0: max0=max(max0, str0); else max1=max(max1, str1);
    - ptr++; after slot N_DRV-1 go to COMMIT.
    - SCAN lasts exactly N_DRV cycles.
  - COMMIT: drv_ready_o=0. Compute the new net value:
    - max0=max1=0 -> Z;
    - max1>max0 -> 1;
    - max0>max1 -> 0;
    - equal and nonzero -> X.
    - Register net_o.
    - net_changed_o=1 if new != old.
    - finish_o=1 if new=01 and old!=01.
    - If new=X, conflict_cnt_o++ (saturating at all-ones). The count increments on every X commit, even if the net was already X.
    - Return to IDLE.
- Latency: request accepted at edge t; net_o and pulses are visible after edge t+N_DRV+1. The next request can be accepted at edge t+N_DRV+2.
- Pulses are high for exactly the one cycle following the COMMIT edge and are 0 otherwise.
- A write to a slot with identical contents still runs a full scan and commit; net_changed_o=0 in that case.
- Strength ties between drivers of the same value are irrelevant; only the maxima matter.
- Inputs are ignored while drv_ready_o=0. The requester must hold its request until accepted.

Decomposition:
- Package strength_pkg:
  - strength_t enum (STR_W bits, the 8 codes above);
  - net_t 2-bit enum (NET_0, NET_1, NET_Z, NET_X);
  - function resolve(max0, max1) returning net_t.
- One natural sub-module, strength_scan_acc: holds the max0/max1 accumulators and ptr, with clear/step inputs and a done output.
- The FSM, slot storage and outputs stay in the top module.

Test Plan:
- Reset then idle -> net_o=10, conflict_cnt_o=0, drv_ready_o=1, no pulses.
- Write slot0 val1 str1=6 (strong), then slot1 val0 str0=3 (weak), then slot2 val0 str0=5 (pull):
  - net_o=01 after the first commit, with net_changed_o and finish_o pulsing once;
  - the later commits stay 01 with no pulses.
- Slot0 val1 str1=5 and slot1 val0 str0=5 -> net_o=11, conflict_cnt_o=1.
  - Then rewrite slot1 with str0=0 -> net_o=01, finish_o pulse.
- All slots released (str=0) -> net_o=10 with a change pulse.
- Hold valid high continuously -> requests accepted exactly every N_DRV+2 cycles; ready low during SCAN/COMMIT.
- Assert rst_n=0 mid-SCAN -> no commit, state IDLE, slots cleared, net_o=10.
- Idx=3 with N_DRV=3 -> dropped, no busy, no pulses.
- 256 X commits with CNT_W=8 -> counter saturates at 255.
